// File: rtl/wb_stage_v2.sv
// Writeback stage: byte-lane regfile writes with back-pressure from a shared
// write port, precise exception commit, and a retired-instruction counter.
module wb_stage_v2 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 32,
    localparam int BE_W   = DATA_W / 8,
    localparam int BUS_WD = 1 + 5 + BE_W + ADDR_W + DATA_W + PC_W
) (
    input  logic                              clk,
    input  logic                              reset,
    output logic                              ws_allowin,
    input  logic                              ms_to_ws_valid,
    input  logic [BUS_WD-1:0]                 ms_to_ws_bus,
    input  logic                              rf_ready,
    output logic [BE_W-1:0]                   rf_we,
    output logic [ADDR_W-1:0]                 rf_waddr,
    output logic [DATA_W-1:0]                 rf_wdata,
    output logic [1+BE_W+ADDR_W+DATA_W-1:0]   ws_to_ds_bus,
    output logic                              ws_flush,
    output logic [PC_W-1:0]                   ws_epc,
    output logic [4:0]                        ws_excode,
    output logic [CNT_W-1:0]                  retire_cnt,
    output logic [PC_W-1:0]                   debug_wb_pc,
    output logic [BE_W-1:0]                   debug_wb_rf_wen,
    output logic [ADDR_W-1:0]                 debug_wb_rf_wnum,
    output logic [DATA_W-1:0]                 debug_wb_rf_wdata
);

    logic              ws_valid;
    logic [BUS_WD-1:0] payload;

    logic              ex;
    logic [4:0]        excode;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] result;
    logic [PC_W-1:0]   pc;

    logic              needs_port;
    logic              ws_ready_go;
    logic              retire;

    assign ex     = payload[BUS_WD-1];
    assign excode = payload[BUS_WD-2 -: 5];
    assign be     = payload[PC_W+DATA_W+ADDR_W +: BE_W];
    assign dest   = payload[PC_W+DATA_W +: ADDR_W];
    assign result = payload[PC_W +: DATA_W];
    assign pc     = payload[PC_W-1:0];

    // Excepting and be==0 instructions never occupy the shared port, so they never stall
    assign needs_port  = ws_valid && !ex && (be != '0);
    assign ws_ready_go = !needs_port || rf_ready;
    assign ws_allowin  = !ws_valid || ws_ready_go;
    assign ws_flush    = ws_valid && ex;
    assign retire      = ws_valid && !ex && ws_ready_go;

    assign rf_we        = {BE_W{ws_valid && !ex}} & be;
    assign rf_waddr     = dest;
    assign rf_wdata     = result;
    assign ws_to_ds_bus = {ws_valid, rf_we, rf_waddr, rf_wdata};

    assign debug_wb_pc       = pc;
    assign debug_wb_rf_wen   = rf_we & {BE_W{rf_ready}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid   <= 1'b0;
            payload    <= '0;
            ws_epc     <= '0;
            ws_excode  <= '0;
            retire_cnt <= '0;
        end else begin
            // A flush squashes whatever MS offers in the same cycle
            if (ws_allowin) begin
                ws_valid <= ms_to_ws_valid && !ws_flush;
            end
            if (ms_to_ws_valid && ws_allowin) begin
                payload <= ms_to_ws_bus;
            end
            if (ws_flush) begin
                ws_epc    <= pc;
                ws_excode <= excode;
            end
            if (retire) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_stage_v2.sv
// Directed self-checking bench for wb_stage_v2 (4-bit retire counter to reach wrap).
module tb_wb_stage_v2;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int PC_W   = 32;
    localparam int CNT_W  = 4;
    localparam int BE_W   = DATA_W / 8;
    localparam int BUS_WD = 1 + 5 + BE_W + ADDR_W + DATA_W + PC_W;
    localparam int FWD_W  = 1 + BE_W + ADDR_W + DATA_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              ws_allowin;
    logic              ms_to_ws_valid;
    logic [BUS_WD-1:0] ms_to_ws_bus;
    logic              rf_ready;
    logic [BE_W-1:0]   rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [FWD_W-1:0]  ws_to_ds_bus;
    logic              ws_flush;
    logic [PC_W-1:0]   ws_epc;
    logic [4:0]        ws_excode;
    logic [CNT_W-1:0]  retire_cnt;
    logic [PC_W-1:0]   debug_wb_pc;
    logic [BE_W-1:0]   debug_wb_rf_wen;
    logic [ADDR_W-1:0] debug_wb_rf_wnum;
    logic [DATA_W-1:0] debug_wb_rf_wdata;

    int n_assert = 0;
    int n_fail   = 0;

    wb_stage_v2 #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .PC_W  (PC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .ws_allowin       (ws_allowin),
        .ms_to_ws_valid   (ms_to_ws_valid),
        .ms_to_ws_bus     (ms_to_ws_bus),
        .rf_ready         (rf_ready),
        .rf_we            (rf_we),
        .rf_waddr         (rf_waddr),
        .rf_wdata         (rf_wdata),
        .ws_to_ds_bus     (ws_to_ds_bus),
        .ws_flush         (ws_flush),
        .ws_epc           (ws_epc),
        .ws_excode        (ws_excode),
        .retire_cnt       (retire_cnt),
        .debug_wb_pc      (debug_wb_pc),
        .debug_wb_rf_wen  (debug_wb_rf_wen),
        .debug_wb_rf_wnum (debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    function automatic logic [BUS_WD-1:0] mk(input logic ex, input logic [4:0] code,
                                             input logic [3:0] be, input logic [4:0] dest,
                                             input logic [31:0] res, input logic [31:0] pc);
        return {ex, code, be, dest, res, pc};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then leave 1 time unit for outputs to settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        ms_to_ws_valid = 1'b0;
        ms_to_ws_bus   = '0;
        rf_ready       = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_allowin", ws_allowin, 1);
        check("rst_rf_we", rf_we, 0);
        check("rst_flush", ws_flush, 0);
        check("rst_fwd", ws_to_ds_bus, 0);
        check("rst_cnt", retire_cnt, 0);
        check("rst_epc", ws_epc, 0);
        check("rst_excode", ws_excode, 0);
        check("rst_dbg_wen", debug_wb_rf_wen, 0);

        // Back-to-back full writes
        ms_to_ws_valid = 1'b1;
        ms_to_ws_bus   = mk(1'b0, 5'd0, 4'hF, 5'd3, 32'h11111111, 32'h00000100);
        tick();
        ms_to_ws_bus = mk(1'b0, 5'd0, 4'hF, 5'd4, 32'h22222222, 32'h00000104);
        #1;
        check("b2b_a_we", rf_we, 4'hF);
        check("b2b_a_waddr", rf_waddr, 3);
        check("b2b_a_wdata", rf_wdata, 32'h11111111);
        check("b2b_a_allowin", ws_allowin, 1);
        check("b2b_a_cnt", retire_cnt, 0);
        tick();
        ms_to_ws_valid = 1'b0;
        #1;
        check("b2b_b_we", rf_we, 4'hF);
        check("b2b_b_waddr", rf_waddr, 4);
        check("b2b_b_wdata", rf_wdata, 32'h22222222);
        check("b2b_b_allowin", ws_allowin, 1);
        check("b2b_b_cnt", retire_cnt, 1);
        tick();
        check("b2b_end_cnt", retire_cnt, 2);
        check("b2b_end_we", rf_we, 0);

        // Partial byte-lane write
        ms_to_ws_valid = 1'b1;
        ms_to_ws_bus   = mk(1'b0, 5'd0, 4'b0011, 5'd7, 32'hAABBCCDD, 32'h00000108);
        tick();
        ms_to_ws_valid = 1'b0;
        #1;
        check("part_we", rf_we, 4'b0011);
        check("part_wdata", rf_wdata, 32'hAABBCCDD);
        check("part_dbg_wen", debug_wb_rf_wen, 4'b0011);
        check("part_dbg_pc", debug_wb_pc, 32'h00000108);
        check("part_dbg_wnum", debug_wb_rf_wnum, 7);
        check("part_fwd", ws_to_ds_bus, {1'b1, 4'b0011, 5'd7, 32'hAABBCCDD});
        tick();
        check("part_cnt", retire_cnt, 3);

        // Stall 3 cycles on rf_ready=0 while MS holds the next instruction
        rf_ready       = 1'b0;
        ms_to_ws_valid = 1'b1;
        ms_to_ws_bus   = mk(1'b0, 5'd0, 4'hF, 5'd9, 32'h12345678, 32'h0000010C);
        tick();
        ms_to_ws_bus = mk(1'b0, 5'd0, 4'hF, 5'd10, 32'h9ABCDEF0, 32'h00000110);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("stall_allowin", ws_allowin, 0);
            check("stall_we", rf_we, 4'hF);
            check("stall_waddr", rf_waddr, 9);
            check("stall_wdata", rf_wdata, 32'h12345678);
            check("stall_dbg_wen", debug_wb_rf_wen, 0);
            check("stall_cnt", retire_cnt, 3);
            check("stall_fwd_valid", ws_to_ds_bus[FWD_W-1], 1);
            tick();
        end
        rf_ready = 1'b1;
        #1;
        check("unstall_allowin", ws_allowin, 1);
        check("unstall_dbg_wen", debug_wb_rf_wen, 4'hF);
        tick();
        ms_to_ws_valid = 1'b0;
        #1;
        check("unstall_cnt", retire_cnt, 4);
        check("held_next_waddr", rf_waddr, 10);
        check("held_next_wdata", rf_wdata, 32'h9ABCDEF0);
        tick();
        check("held_next_cnt", retire_cnt, 5);

        // be==0 does not need the port, so no stall
        ms_to_ws_valid = 1'b1;
        ms_to_ws_bus   = mk(1'b0, 5'd0, 4'h0, 5'd11, 32'hDEADBEEF, 32'h00000114);
        tick();
        ms_to_ws_valid = 1'b0;
        rf_ready       = 1'b0;
        #1;
        check("be0_allowin", ws_allowin, 1);
        check("be0_we", rf_we, 0);
        check("be0_fwd_valid", ws_to_ds_bus[FWD_W-1], 1);
        tick();
        check("be0_cnt", retire_cnt, 6);

        // Exception with a younger instruction arriving the same cycle
        rf_ready       = 1'b1;
        ms_to_ws_valid = 1'b1;
        ms_to_ws_bus   = mk(1'b1, 5'h04, 4'hF, 5'd12, 32'h55555555, 32'hBFC00380);
        tick();
        ms_to_ws_bus = mk(1'b0, 5'd0, 4'hF, 5'd13, 32'h66666666, 32'h00000118);
        #1;
        check("exc_flush", ws_flush, 1);
        check("exc_we", rf_we, 0);
        check("exc_dbg_wen", debug_wb_rf_wen, 0);
        check("exc_allowin", ws_allowin, 1);
        tick();
        ms_to_ws_valid = 1'b0;
        #1;
        check("exc_flush_gone", ws_flush, 0);
        check("exc_epc", ws_epc, 32'hBFC00380);
        check("exc_excode", ws_excode, 5'h04);
        check("exc_squash_valid", ws_to_ds_bus[FWD_W-1], 0);
        check("exc_squash_we", rf_we, 0);
        check("exc_cnt", retire_cnt, 6);

        // Reset while stalled
        rf_ready       = 1'b0;
        ms_to_ws_valid = 1'b1;
        ms_to_ws_bus   = mk(1'b0, 5'd0, 4'hF, 5'd14, 32'h77777777, 32'h0000011C);
        tick();
        ms_to_ws_valid = 1'b0;
        #1;
        check("pre_rst_allowin", ws_allowin, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_valid", ws_to_ds_bus[FWD_W-1], 0);
        check("mid_rst_we", rf_we, 0);
        check("mid_rst_cnt", retire_cnt, 0);
        check("mid_rst_allowin", ws_allowin, 1);
        check("mid_rst_flush", ws_flush, 0);
        check("mid_rst_epc", ws_epc, 0);

        // 17 retirements wrap the 4-bit counter to 1
        rf_ready       = 1'b1;
        ms_to_ws_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            ms_to_ws_bus = mk(1'b0, 5'd0, 4'hF, 5'(i), 32'(i), 32'h00000200 + 32'(4 * i));
            tick();
            if (i == 15) check("wrap_cnt_15", retire_cnt, 4'hF);
        end
        ms_to_ws_valid = 1'b0;
        #1;
        check("wrap_cnt_0", retire_cnt, 0);
        tick();
        check("wrap_cnt_1", retire_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
